// File: rtl/ram_tick_gen.sv
// ram_clk-domain reset stretcher, host_clk phase mirror and programmable PWM prescaler tick.
// The prescale value is loaded from the host domain through a toggle req/ack handshake.
module ram_tick_gen #(
   parameter int unsigned RST_STRETCH = 16,
   parameter int unsigned PRESC_W     = 16,
   parameter int unsigned PRESC_RST   = 119
) (
   input  logic               ram_clk,
   input  logic               sys_rst_l,
   input  logic               presc_req,
   input  logic [PRESC_W-1:0] presc_data,
   output logic               ram_rst_l,
   output logic               host_phase,
   output logic               pwm_tick,
   output logic               presc_ack,
   output logic [PRESC_W-1:0] presc_cur
);

   localparam logic [7:0]         STRETCH_MAX = 8'(RST_STRETCH - 1);
   localparam logic [PRESC_W-1:0] PRESC_INIT  = PRESC_W'(PRESC_RST);

   logic               rs1, rs2;
   logic [7:0]         stretch_cnt;
   logic               req_s1, req_s2, req_s3;
   logic               load;
   logic [PRESC_W-1:0] cnt;

   assign load = req_s2 ^ req_s3;

   // Reset synchroniser and stretch counter; ram_rst_l also serves as the prescaler run flag.
   always_ff @(posedge ram_clk or negedge sys_rst_l) begin
      if (!sys_rst_l) begin
         rs1         <= 1'b0;
         rs2         <= 1'b0;
         stretch_cnt <= 8'd0;
         ram_rst_l   <= 1'b0;
      end else begin
         rs1 <= 1'b1;
         rs2 <= rs1;
         if (rs2 && !ram_rst_l) begin
            if (stretch_cnt == STRETCH_MAX) begin
               ram_rst_l <= 1'b1;
            end else begin
               stretch_cnt <= stretch_cnt + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge ram_clk or negedge sys_rst_l) begin
      if (!sys_rst_l) begin
         host_phase <= 1'b0;
      end else begin
         host_phase <= ~host_phase;
      end
   end

   always_ff @(posedge ram_clk or negedge sys_rst_l) begin
      if (!sys_rst_l) begin
         req_s1 <= 1'b0;
         req_s2 <= 1'b0;
         req_s3 <= 1'b0;
      end else begin
         req_s1 <= presc_req;
         req_s2 <= req_s1;
         req_s3 <= req_s2;
      end
   end

   // A load wins over terminal count so the new period starts cleanly without a stray tick.
   always_ff @(posedge ram_clk or negedge sys_rst_l) begin
      if (!sys_rst_l) begin
         presc_cur <= PRESC_INIT;
         cnt       <= PRESC_INIT;
         pwm_tick  <= 1'b0;
         presc_ack <= 1'b0;
      end else if (load) begin
         presc_cur <= presc_data;
         cnt       <= presc_data;
         pwm_tick  <= 1'b0;
         presc_ack <= ~presc_ack;
      end else if (!ram_rst_l) begin
         cnt      <= presc_cur;
         pwm_tick <= 1'b0;
      end else if (cnt == '0) begin
         cnt      <= presc_cur;
         pwm_tick <= 1'b1;
      end else begin
         cnt      <= cnt - 1'b1;
         pwm_tick <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ram_tick_gen.sv
// Directed bench for ram_tick_gen: reset stretch, tick spacing, load handshake,
// mid-count reset and host_phase against a divide-by-2 model.
module tb_ram_tick_gen;

   logic        ram_clk = 1'b0;
   logic        sys_rst_l;
   logic        presc_req;
   logic [15:0] presc_data;
   logic        ram_rst_l;
   logic        host_phase;
   logic        pwm_tick;
   logic        presc_ack;
   logic [15:0] presc_cur;

   int   n_cmp = 0;
   int   n_err = 0;
   logic exp_ack;
   logic model_phase;

   ram_tick_gen dut (
      .ram_clk    (ram_clk),
      .sys_rst_l  (sys_rst_l),
      .presc_req  (presc_req),
      .presc_data (presc_data),
      .ram_rst_l  (ram_rst_l),
      .host_phase (host_phase),
      .pwm_tick   (pwm_tick),
      .presc_ack  (presc_ack),
      .presc_cur  (presc_cur)
   );

   always #5 ram_clk = ~ram_clk;

   always_ff @(posedge ram_clk or negedge sys_rst_l) begin
      if (!sys_rst_l) model_phase <= 1'b0;
      else            model_phase <= ~model_phase;
   end

   task automatic step();
      @(posedge ram_clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Releases reset between edges and checks edges 1..last against the default schedule.
   task automatic release_and_run(input int last);
      @(negedge ram_clk);
      sys_rst_l = 1'b1;
      for (int e = 1; e <= last; e++) begin
         step();
         chk1("ram_rst_l", ram_rst_l, e >= 18);
         chk1("pwm_tick_dflt", pwm_tick, (e == 138) || (e == 258));
         if (e <= 18) chk1("host_phase_rel", host_phase, e[0]);
      end
      chk1("ack_after_rel", presc_ack, 1'b0);
      chk16("cur_after_rel", presc_cur, 16'd119);
   endtask

   // Toggle at edge N-1+1us, updates expected at N+2; ends sampled after N+2.
   task automatic do_load(input logic [15:0] d);
      presc_data = d;
      presc_req  = ~presc_req;
      step();
      chk1("ack_n", presc_ack, exp_ack);
      step();
      chk1("ack_n1", presc_ack, exp_ack);
      step();
      exp_ack = ~exp_ack;
      chk1("ack_n2", presc_ack, exp_ack);
      chk16("cur_n2", presc_cur, d);
   endtask

   // k=0 is the load edge; a tick follows every d+1 edges after it.
   task automatic tick_pattern(input logic [15:0] d, input int kmax);
      for (int k = 0; k <= kmax; k++) begin
         if (k > 0) step();
         chk1("tick_pat", pwm_tick, (k > 0) && ((k % (int'(d) + 1)) == 0));
      end
   endtask

   task automatic chk_reset_vals();
      chk1("rst_ram_rst_l", ram_rst_l, 1'b0);
      chk1("rst_host_phase", host_phase, 1'b0);
      chk1("rst_pwm_tick", pwm_tick, 1'b0);
      chk1("rst_presc_ack", presc_ack, 1'b0);
      chk16("rst_presc_cur", presc_cur, 16'd119);
   endtask

   initial begin
      sys_rst_l  = 1'b1;
      presc_req  = 1'b0;
      presc_data = 16'd0;
      exp_ack    = 1'b0;
      #1 sys_rst_l = 1'b0;
      #1 chk_reset_vals();
      step();
      step();
      chk_reset_vals();

      release_and_run(260);

      do_load(16'd4);
      tick_pattern(16'd4, 16);
      do_load(16'd0);
      tick_pattern(16'd0, 6);
      do_load(16'd2);
      tick_pattern(16'd2, 9);
      // cnt reaches 0 right before this load lands, so that edge must not tick.
      do_load(16'd3);
      tick_pattern(16'd3, 8);
      do_load(16'd4);
      tick_pattern(16'd4, 7);

      sys_rst_l = 1'b0;
      #1 chk_reset_vals();
      presc_req = 1'b0;
      exp_ack   = 1'b0;
      step();
      step();
      chk_reset_vals();
      release_and_run(140);

      for (int i = 0; i < 1000; i++) begin
         step();
         chk1("host_phase_model", host_phase, model_phase);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
